// File: rtl/shift_seq_ctrl_pkg.sv
// ============================================================================
// shift_seq_ctrl_pkg : shared state encoding and mode/direction constants
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PREP  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic MODE_TX = 1'b0;
   localparam logic MODE_RX = 1'b1;
   localparam logic DIR_R   = 1'b0;
   localparam logic DIR_L   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/shift_seq_ctrl_if.sv
// ============================================================================
// shift_seq_ctrl_if : request side and shift-register side of the sequencer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_seq_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH) + 1
);
   logic             start;
   logic             mode;
   logic             dir;
   logic [CW-1:0]    nbits;
   logic [WIDTH-1:0] din;
   logic             abort;
   logic             sdi;
   logic [WIDTH-1:0] sr_dout;

   logic             sr_cl;
   logic             sr_w;
   logic [WIDTH-1:0] sr_din;
   logic             sr_shr;
   logic             sr_shl;
   logic             sr_shift_bit;
   logic             sdo;
   logic             sdo_valid;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] dout;

   modport master (
      output start, mode, dir, nbits, din, abort, sdi, sr_dout,
      input  sr_cl, sr_w, sr_din, sr_shr, sr_shl, sr_shift_bit,
             sdo, sdo_valid, ready, busy, done, dout
   );

   modport slave (
      input  start, mode, dir, nbits, din, abort, sdi, sr_dout,
      output sr_cl, sr_w, sr_din, sr_shr, sr_shl, sr_shift_bit,
             sdo, sdo_valid, ready, busy, done, dout
   );
endinterface

`default_nettype wire

// File: rtl/shift_bit_counter.sv
// ============================================================================
// shift_bit_counter : loadable down-counter that saturates at zero
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_bit_counter #(
   parameter int CW = 4
) (
   input  wire          clk,
   input  wire          rst,
   input  wire          i_load,
   input  wire [CW-1:0] i_load_val,
   input  wire          i_dec,
   output logic         o_last
);
   logic [CW-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign o_last = (r_count == CW'(1));

endmodule

`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
// ============================================================================
// shift_seq_ctrl : word-to-serial sequencer driving an external shift register
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq_ctrl
   import shift_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input wire              clk,
   input wire              rst,
   shift_seq_ctrl_if.slave bus
);
   localparam logic [CW-1:0] C_NMAX = CW'(WIDTH);

   state_t           r_state;
   logic             r_mode;
   logic             r_dir;
   logic [CW-1:0]    r_n;
   logic [WIDTH-1:0] r_din;
   logic [WIDTH-1:0] r_dout;

   logic [CW-1:0]    w_n_eff;
   logic [CW-1:0]    w_rshamt;
   logic [WIDTH-1:0] w_rx_word;
   logic             w_last;
   logic             w_load;
   logic             w_dec;

   assign w_n_eff   = ((bus.nbits == '0) || (bus.nbits > C_NMAX)) ? C_NMAX : bus.nbits;
   // shr fills from the MSB, so a short RX word sits at the top and is right-aligned here
   assign w_rshamt  = C_NMAX - r_n;
   assign w_rx_word = (r_dir == DIR_R) ? (bus.sr_dout >> w_rshamt) : bus.sr_dout;

   assign w_load = (r_state == ST_PREP);
   assign w_dec  = (r_state == ST_SHIFT) && !bus.abort;

   shift_bit_counter #(
      .CW (CW)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (r_n),
      .i_dec      (w_dec),
      .o_last     (w_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_mode  <= MODE_TX;
         r_dir   <= DIR_R;
         r_n     <= '0;
         r_din   <= '0;
         r_dout  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_mode  <= bus.mode;
                  r_dir   <= bus.dir;
                  r_n     <= w_n_eff;
                  r_din   <= bus.din;
                  r_state <= ST_PREP;
               end
            end
            ST_PREP: begin
               r_state <= bus.abort ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
               if (bus.abort) begin
                  r_state <= ST_IDLE;
               end else if (w_last) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (r_mode == MODE_RX) begin
                  r_dout <= w_rx_word;
               end
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.sr_cl        = 1'b0;
      bus.sr_w         = 1'b0;
      bus.sr_din       = '0;
      bus.sr_shr       = 1'b0;
      bus.sr_shl       = 1'b0;
      bus.sr_shift_bit = 1'b0;
      bus.sdo          = 1'b0;
      bus.sdo_valid    = 1'b0;
      bus.done         = 1'b0;
      bus.ready        = (r_state == ST_IDLE);
      bus.busy         = (r_state != ST_IDLE);
      bus.dout         = r_dout;
      case (r_state)
         ST_PREP: begin
            if (bus.abort || (r_mode == MODE_RX)) begin
               bus.sr_cl = 1'b1;
            end else begin
               bus.sr_w   = 1'b1;
               bus.sr_din = r_din;
            end
         end
         ST_SHIFT: begin
            // abort clears the register instead of shifting, keeping controls one-hot
            if (bus.abort) begin
               bus.sr_cl = 1'b1;
            end else begin
               bus.sr_shr = (r_dir == DIR_R);
               bus.sr_shl = (r_dir == DIR_L);
               if (r_mode == MODE_TX) begin
                  bus.sdo       = (r_dir == DIR_R) ? bus.sr_dout[0] : bus.sr_dout[WIDTH-1];
                  bus.sdo_valid = 1'b1;
               end else begin
                  bus.sr_shift_bit = bus.sdi;
               end
            end
         end
         ST_DONE: begin
            bus.done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire
